// File: rtl/alu_ctrl_exec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_ctrl_exec                                                 |
// | Purpose  : Decode/execute slice of the 16-bit five-stage pipeline.       |
// |            Decodes one instruction per cycle into control bits, runs     |
// |            the byte-lane ALU, forms the next PC, and registers all       |
// |            outputs once.                                                 |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            instr[15:0]  opcode/cond/lane/rd/rs1/rs2-imm3-offset/imm8     |
// |            pc[7:0], op_a[15:0], op_b[15:0]                               |
// |            next_pc[7:0], result[15:0], flag, regwr[1:0], memwr,          |
// |            wrbk_sel, dir_val[1:0], jmp, eop                              |
// | Options  : define MUL_EN to build the opcode-9 multiplier; otherwise     |
// |            opcode 9 decodes as NOP and no multiplier exists.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module alu_ctrl_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic [7:0]  pc,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic [7:0]  next_pc,
  output logic [15:0] result,
  output logic        flag,
  output logic [1:0]  regwr,
  output logic        memwr,
  output logic        wrbk_sel,
  output logic [1:0]  dir_val,
  output logic        jmp,
  output logic        eop
);

  localparam logic [3:0] c_OP_NOP   = 4'h0;
  localparam logic [3:0] c_OP_ADD   = 4'h1;
  localparam logic [3:0] c_OP_SUB   = 4'h2;
  localparam logic [3:0] c_OP_AND   = 4'h3;
  localparam logic [3:0] c_OP_OR    = 4'h4;
  localparam logic [3:0] c_OP_XOR   = 4'h5;
  localparam logic [3:0] c_OP_NOT   = 4'h6;
  localparam logic [3:0] c_OP_SHL   = 4'h7;
  localparam logic [3:0] c_OP_SHR   = 4'h8;
  localparam logic [3:0] c_OP_MUL   = 4'h9;
  localparam logic [3:0] c_OP_LDI   = 4'hA;
  localparam logic [3:0] c_OP_LOAD  = 4'hB;
  localparam logic [3:0] c_OP_STORE = 4'hC;
  localparam logic [3:0] c_OP_ADDI  = 4'hD;
  localparam logic [3:0] c_OP_JMP   = 4'hE;
  localparam logic [3:0] c_OP_EOP   = 4'hF;

  localparam logic [1:0] c_LANE_NONE = 2'b00;
  localparam logic [1:0] c_LANE_LO   = 2'b01;
  localparam logic [1:0] c_LANE_HI   = 2'b10;

  // Instruction fields
  logic [3:0] w_op;
  logic       w_cond;
  logic [1:0] w_lane;
  logic [2:0] w_imm3;
  logic [7:0] w_imm8;
  logic       w_unused;

  assign w_op     = instr[15:12];
  assign w_cond   = instr[11];
  assign w_lane   = instr[10:9];
  assign w_imm3   = instr[2:0];
  assign w_imm8   = instr[7:0];
  assign w_unused = instr[8];   // rd[2] is only consumed by the register file

  // Registered outputs
  logic [7:0]  r_next_pc;
  logic [15:0] r_result;
  logic        r_flag;
  logic [1:0]  r_regwr;
  logic        r_memwr;
  logic        r_wrbk_sel;
  logic [1:0]  r_dir_val;
  logic        r_jmp;
  logic        r_eop;

  // Lane operands are right-justified and zero-extended, so a single
  // datapath serves both the 8-bit and 16-bit cases; the carry position
  // and the final mask are what differ.
  logic        w_is8;
  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [15:0] w_badd;
  logic [15:0] w_mask;
  logic [16:0] w_sum;
  logic [15:0] w_diff;

  assign w_is8  = (w_lane != 2'b11);
  assign w_a    = (w_lane == c_LANE_HI) ? {8'h00, op_a[15:8]} :
                  (w_lane == c_LANE_LO) ? {8'h00, op_a[7:0]}  : op_a;
  assign w_b    = (w_lane == c_LANE_HI) ? {8'h00, op_b[15:8]} :
                  (w_lane == c_LANE_LO) ? {8'h00, op_b[7:0]}  : op_b;
  assign w_badd = (w_op == c_OP_ADDI) ? {13'h0000, w_imm3} : w_b;
  assign w_mask = w_is8 ? 16'h00FF : 16'hFFFF;
  assign w_sum  = {1'b0, w_a} + {1'b0, w_badd};
  assign w_diff = w_a - w_b;

  // ALU: raw lane result, carry/borrow, and which flag source applies
  logic [15:0] w_raw;
  logic        w_carry;
  logic        w_alu_op;     // opcode writes an ALU result
  logic        w_carry_op;   // flag is carry/borrow rather than zero
  logic [15:0] w_lres;
  logic [15:0] w_placed;

  always_comb begin
    w_raw      = 16'h0000;
    w_carry    = 1'b0;
    w_alu_op   = 1'b1;
    w_carry_op = 1'b0;
    case (w_op)
      c_OP_ADD, c_OP_ADDI: begin
        w_raw      = w_sum[15:0];
        w_carry    = w_is8 ? w_sum[8] : w_sum[16];
        w_carry_op = 1'b1;
      end
      c_OP_SUB: begin
        w_raw      = w_diff;
        w_carry    = (w_a < w_b);
        w_carry_op = 1'b1;
      end
      c_OP_AND: w_raw = w_a & w_b;
      c_OP_OR:  w_raw = w_a | w_b;
      c_OP_XOR: w_raw = w_a ^ w_b;
      c_OP_NOT: w_raw = ~w_a;
      // Counts past the lane width shift every lane bit out before masking
      c_OP_SHL: w_raw = w_a << w_b[3:0];
      c_OP_SHR: w_raw = w_a >> w_b[3:0];
`ifdef MUL_EN
      c_OP_MUL: w_raw = 16'(w_a[7:0]) * 16'(w_b[7:0]);
`endif
      default:  w_alu_op = 1'b0;
    endcase
  end

  assign w_lres   = w_raw & w_mask;
  assign w_placed = (w_lane == c_LANE_HI) ? {w_lres[7:0], 8'h00} : w_lres;

  // Decode and next-state selection
  logic [7:0]  w_next_pc;
  logic [15:0] w_result;
  logic        w_flag;
  logic [1:0]  w_regwr;
  logic        w_memwr;
  logic        w_wrbk_sel;
  logic [1:0]  w_dir_val;
  logic        w_jmp;
  logic        w_eop;
  logic        w_taken;

  // A conditional jump sees the flag as registered before this edge
  assign w_taken = ~w_cond | r_flag;

  always_comb begin
    w_next_pc  = pc + 8'd1;
    w_result   = 16'h0000;
    w_flag     = r_flag;
    w_regwr    = 2'b00;
    w_memwr    = 1'b0;
    w_wrbk_sel = 1'b0;
    w_dir_val  = 2'b00;
    w_jmp      = 1'b0;
    w_eop      = 1'b0;
    if (r_eop) begin
      // Halted: freeze PC, result and flag; no writes, no jumps
      w_next_pc = r_next_pc;
      w_result  = r_result;
      w_eop     = 1'b1;
    end else if (w_alu_op) begin
      if (w_op == c_OP_ADDI) begin
        w_dir_val = 2'b01;
      end
      if (w_lane != c_LANE_NONE) begin
        w_result = w_placed;
        w_regwr  = w_lane;
        w_flag   = w_carry_op ? w_carry : (w_placed == 16'h0000);
      end
    end else begin
      case (w_op)
        c_OP_LDI: begin
          w_dir_val = 2'b10;
          w_regwr   = w_lane;
          w_flag    = 1'b0;
          case (w_lane)
            c_LANE_NONE: w_result = 16'h0000;
            c_LANE_HI:   w_result = {w_imm8, 8'h00};
            default:     w_result = {8'h00, w_imm8};
          endcase
        end
        c_OP_LOAD: begin
          w_wrbk_sel = 1'b1;
          w_regwr    = w_lane;
        end
        c_OP_STORE: begin
          w_memwr  = 1'b1;
          w_result = op_a;
        end
        c_OP_JMP: begin
          w_jmp = w_taken;
          if (w_taken && (w_imm3 != 3'd0)) begin
            w_next_pc = pc + {5'd0, w_imm3};
          end
        end
        c_OP_EOP: begin
          // The halting instruction already holds the PC on itself
          w_eop     = 1'b1;
          w_next_pc = pc;
          w_result  = r_result;
        end
        default: ;  // NOP (and opcode 9 without the multiplier)
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_pc  <= 8'h00;
      r_result   <= 16'h0000;
      r_flag     <= 1'b0;
      r_regwr    <= 2'b00;
      r_memwr    <= 1'b0;
      r_wrbk_sel <= 1'b0;
      r_dir_val  <= 2'b00;
      r_jmp      <= 1'b0;
      r_eop      <= 1'b0;
    end else begin
      r_next_pc  <= w_next_pc;
      r_result   <= w_result;
      r_flag     <= w_flag;
      r_regwr    <= w_regwr;
      r_memwr    <= w_memwr;
      r_wrbk_sel <= w_wrbk_sel;
      r_dir_val  <= w_dir_val;
      r_jmp      <= w_jmp;
      r_eop      <= w_eop;
    end
  end

  assign next_pc  = r_next_pc;
  assign result   = r_result;
  assign flag     = r_flag;
  assign regwr    = r_regwr;
  assign memwr    = r_memwr;
  assign wrbk_sel = r_wrbk_sel;
  assign dir_val  = r_dir_val;
  assign jmp      = r_jmp;
  assign eop      = r_eop;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_exec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_ctrl_exec                                              |
// | Purpose  : Scoreboard bench for alu_ctrl_exec with directed vectors.     |
// |            The driver queues a hand-computed expectation per applied     |
// |            instruction; a monitor pops and compares after each edge.     |
// | Options  : honours MUL_EN the same way as the design.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_ctrl_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [7:0]  next_pc;
  logic [15:0] result;
  logic        flag;
  logic [1:0]  regwr;
  logic        memwr;
  logic        wrbk_sel;
  logic [1:0]  dir_val;
  logic        jmp;
  logic        eop;

  always #5 clk = ~clk;

  alu_ctrl_exec dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .pc       (pc),
    .op_a     (op_a),
    .op_b     (op_b),
    .next_pc  (next_pc),
    .result   (result),
    .flag     (flag),
    .regwr    (regwr),
    .memwr    (memwr),
    .wrbk_sel (wrbk_sel),
    .dir_val  (dir_val),
    .jmp      (jmp),
    .eop      (eop)
  );

  typedef struct packed {
    logic [7:0]  np;
    logic [15:0] res;
    logic        flg;
    logic [1:0]  rw;
    logic        mw;
    logic        wb;
    logic [1:0]  dv;
    logic        j;
    logic        e;
  } exp_t;

  typedef struct {
    string name;
    exp_t  e;
  } item_t;

  item_t q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  function automatic exp_t mk(input logic [7:0] np, input logic [15:0] res,
                              input logic flg, input logic [1:0] rw,
                              input logic mw, input logic wb,
                              input logic [1:0] dv, input logic j,
                              input logic e);
    exp_t x;
    x.np = np; x.res = res; x.flg = flg; x.rw = rw; x.mw = mw;
    x.wb = wb; x.dv = dv; x.j = j; x.e = e;
    return x;
  endfunction

  task automatic check(input string nm, input exp_t e);
    exp_t g;
    g.np = next_pc; g.res = result; g.flg = flag; g.rw = regwr; g.mw = memwr;
    g.wb = wrbk_sel; g.dv = dir_val; g.j = jmp; g.e = eop;
    n_vec++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got np=%h res=%h flag=%b regwr=%b memwr=%b wrbk=%b dir=%b jmp=%b eop=%b, expected np=%h res=%h flag=%b regwr=%b memwr=%b wrbk=%b dir=%b jmp=%b eop=%b",
               nm, g.np, g.res, g.flg, g.rw, g.mw, g.wb, g.dv, g.j, g.e,
               e.np, e.res, e.flg, e.rw, e.mw, e.wb, e.dv, e.j, e.e);
    end
  endtask

  // Monitor: the DUT presents a new registered output every edge
  always @(posedge clk) begin
    item_t it;
    #1;
    if (q.size() > 0) begin
      it = q.pop_front();
      check(it.name, it.e);
    end
  end

  task automatic apply(input string nm, input logic [15:0] i, input logic [7:0] p,
                       input logic [15:0] a, input logic [15:0] b, input exp_t e);
    item_t it;
    @(negedge clk);
    instr = i; pc = p; op_a = a; op_b = b;
    it.name = nm;
    it.e    = e;
    q.push_back(it);
  endtask

  exp_t       e_mul;
  logic [15:0] mul_res;

  initial begin
`ifdef MUL_EN
    mul_res = 16'hFE01;
    e_mul   = mk(8'h0B, 16'hFE01, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
`else
    mul_res = 16'h0000;
    e_mul   = mk(8'h0B, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
`endif
    rst_n = 1'b0; instr = 16'h0000; pc = 8'h04; op_a = 16'h0000; op_b = 16'h0000;
    #2;
    check("reset_init", mk(8'h00, 16'h0000, 0, 2'b00, 0, 0, 2'b00, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;   // the following idle edge executes NOP at pc=4

    //               name          instr     pc     op_a      op_b        np     result    f  regwr mw wb dir  j  e
    apply("nop",       16'h0000, 8'h05, 16'h0000, 16'h0000, mk(8'h06, 16'h0000, 0, 2'b00, 0, 0, 2'b00, 0, 0));
    apply("add_full",  16'h1600, 8'h06, 16'hFFFF, 16'h0001, mk(8'h07, 16'h0000, 1, 2'b11, 0, 0, 2'b00, 0, 0));
    apply("add_lo",    16'h1200, 8'h07, 16'hFFFF, 16'h0001, mk(8'h08, 16'h0000, 1, 2'b01, 0, 0, 2'b00, 0, 0));
    apply("add_hi",    16'h1400, 8'h08, 16'h12FF, 16'h0101, mk(8'h09, 16'h1300, 0, 2'b10, 0, 0, 2'b00, 0, 0));
    apply("ldi_hi",    16'hA4A5, 8'h09, 16'h0000, 16'h0000, mk(8'h0A, 16'hA500, 0, 2'b10, 0, 0, 2'b10, 0, 0));
    apply("addi_lo",   16'hD203, 8'h0A, 16'h0007, 16'h0000, mk(8'h0B, 16'h000A, 0, 2'b01, 0, 0, 2'b01, 0, 0));
    apply("jmp_off3",  16'hE003, 8'h10, 16'h0000, 16'h0000, mk(8'h13, 16'h0000, 0, 2'b00, 0, 0, 2'b00, 1, 0));
    apply("jmp_off0",  16'hE000, 8'h10, 16'h0000, 16'h0000, mk(8'h11, 16'h0000, 0, 2'b00, 0, 0, 2'b00, 1, 0));
    apply("jmp_c1_f0", 16'hE803, 8'h10, 16'h0000, 16'h0000, mk(8'h11, 16'h0000, 0, 2'b00, 0, 0, 2'b00, 0, 0));
    apply("sub_borrow",16'h2600, 8'h20, 16'h0001, 16'h0002, mk(8'h21, 16'hFFFF, 1, 2'b11, 0, 0, 2'b00, 0, 0));
    apply("jmp_c1_wrap",16'hE805,8'hFE, 16'h0000, 16'h0000, mk(8'h03, 16'h0000, 1, 2'b00, 0, 0, 2'b00, 1, 0));
    apply("and_zero",  16'h3600, 8'h03, 16'hF0F0, 16'h0F0F, mk(8'h04, 16'h0000, 1, 2'b11, 0, 0, 2'b00, 0, 0));
    apply("shl_lo",    16'h7200, 8'h04, 16'h0081, 16'h0001, mk(8'h05, 16'h0002, 0, 2'b01, 0, 0, 2'b00, 0, 0));
    apply("shr_hi_8",  16'h8400, 8'h05, 16'h8000, 16'h0808, mk(8'h06, 16'h0000, 1, 2'b10, 0, 0, 2'b00, 0, 0));
    apply("xor_full",  16'h5600, 8'h06, 16'hFF00, 16'h0FF0, mk(8'h07, 16'hF0F0, 0, 2'b11, 0, 0, 2'b00, 0, 0));
    apply("not_lo",    16'h6200, 8'h07, 16'h00F0, 16'h0000, mk(8'h08, 16'h000F, 0, 2'b01, 0, 0, 2'b00, 0, 0));
    apply("store",     16'hC600, 8'h08, 16'h1234, 16'h0000, mk(8'h09, 16'h1234, 0, 2'b00, 1, 0, 2'b00, 0, 0));
    apply("load",      16'hB600, 8'h09, 16'h0000, 16'h0000, mk(8'h0A, 16'h0000, 0, 2'b11, 0, 1, 2'b00, 0, 0));
    apply("mul_full",  16'h9600, 8'h0A, 16'h00FF, 16'h00FF, e_mul);
    apply("eop",       16'hF000, 8'h20, 16'h0000, 16'h0000, mk(8'h20, mul_res,  0, 2'b00, 0, 0, 2'b00, 0, 1));
    apply("eop_add",   16'h1600, 8'h30, 16'h0001, 16'h0001, mk(8'h20, mul_res,  0, 2'b00, 0, 0, 2'b00, 0, 1));
    apply("eop_store", 16'hC600, 8'h31, 16'h5555, 16'h0000, mk(8'h20, mul_res,  0, 2'b00, 0, 0, 2'b00, 0, 1));

    // Asynchronous reset mid-run, between clock edges
    @(posedge clk);
    #3;
    instr = 16'h0000; pc = 8'h04;
    rst_n = 1'b0;
    #1;
    check("reset_async", mk(8'h00, 16'h0000, 0, 2'b00, 0, 0, 2'b00, 0, 0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst_nop", 16'h0000, 8'h05, 16'h0000, 16'h0000, mk(8'h06, 16'h0000, 0, 2'b00, 0, 0, 2'b00, 0, 0));
    apply("post_rst_add", 16'h1600, 8'h06, 16'h0003, 16'h0004, mk(8'h07, 16'h0007, 0, 2'b11, 0, 0, 2'b00, 0, 0));

    // Drain the scoreboard within a bounded number of edges
    for (int k = 0; k < 4 && q.size() > 0; k++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
